// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-requester arbiter and sequencer in front of a single-port, byte-addressed
// data memory. Requester 0 is the CPU load/store stage and requester 1 is the
// debug/DMA port. Each granted request becomes one memory access:
//   IDLE -> ACCESS (strobes high for exactly one cycle) -> RESP (one-cycle ack) -> IDLE
// When both requesters ask at once, round-robin picks the one that did not win last.
//
// Ports
//   Clk, Reset_n          clock, asynchronous active-low reset
//   req, we               per-requester request and write flag
//   addr0/1, wdata0/1     per-requester byte address and write data
//   half0/1, uns0/1       per-requester read size (halfword) and unsigned flag
//   gnt                   one-hot owner of the memory (high during ACCESS)
//   ack, err              one-cycle completion pulse, rejection flag
//   rdata                 read data, valid in the ack cycle
//   mem_address, mem_data_in, MemRead, MemWrite, lh, lhu   memory-side controls
//   mem_data_out          memory read data
//
// Optional feature: define DMEM_ARB_CHECK_EN to reject misaligned or out-of-range
// requests in IDLE. A rejected request skips ACCESS and gets ack+err one cycle later.

module dmem_arbiter #(
    parameter int MEM_BYTES = 64,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        half0,
    input  logic        half1,
    input  logic        uns0,
    input  logic        uns1,
    output logic [1:0]  gnt,
    output logic [1:0]  ack,
    output logic [31:0] rdata,
    output logic [1:0]  err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        lh,
    output logic        lhu,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic        prio;
    logic        win_q;

    logic        win;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_half;
    logic        sel_uns;

    // The memory must hold at least one word for any access to be legal.
    if (MEM_BYTES < 4) begin : g_bad_size
        $error("dmem_arbiter: MEM_BYTES must be at least 4");
    end

    // Winner: a lone requester always wins; on contention the favoured one wins.
    always_comb begin
        win       = (req == 2'b11) ? prio : req[1];
        sel_we    = win ? we[1]  : we[0];
        sel_addr  = win ? addr1  : addr0;
        sel_wdata = win ? wdata1 : wdata0;
        sel_half  = win ? half1  : half0;
        sel_uns   = win ? uns1   : uns0;
    end

`ifdef DMEM_ARB_CHECK_EN
    logic        is_half;
    logic [32:0] last_byte;
    logic        reject;

    // Halfword sizing applies only to reads; writes are always full words.
    // The range sum is one bit wider so an address near 2^32 cannot wrap.
    always_comb begin
        is_half   = sel_half & ~sel_we;
        last_byte = {1'b0, sel_addr} + (is_half ? 33'd1 : 33'd3);
        reject    = (is_half ? sel_addr[0] : (|sel_addr[1:0]))
                  | (last_byte >= 33'(MEM_BYTES));
    end
`else
    assign err = 2'b00;
`endif

    // Single FSM with all outputs registered; reset drops strobes asynchronously.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            prio        <= PRIO_INIT;
            win_q       <= 1'b0;
            gnt         <= 2'b00;
            ack         <= 2'b00;
            rdata       <= 32'h0;
            mem_address <= 32'h0;
            mem_data_in <= 32'h0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            lh          <= 1'b0;
            lhu         <= 1'b0;
`ifdef DMEM_ARB_CHECK_EN
            err         <= 2'b00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack <= 2'b00;
`ifdef DMEM_ARB_CHECK_EN
                    err <= 2'b00;
`endif
                    if (|req) begin
                        prio  <= ~win;
                        win_q <= win;
`ifdef DMEM_ARB_CHECK_EN
                        if (reject) begin
                            ack   <= win ? 2'b10 : 2'b01;
                            err   <= win ? 2'b10 : 2'b01;
                            state <= RESP;
                        end else begin
`else
                        begin
`endif
                            gnt         <= win ? 2'b10 : 2'b01;
                            mem_address <= sel_addr;
                            mem_data_in <= sel_wdata;
                            MemRead     <= ~sel_we;
                            MemWrite    <= sel_we;
                            lh          <= ~sel_we & sel_half & ~sel_uns;
                            lhu         <= ~sel_we & sel_half & sel_uns;
                            state       <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Writes leave rdata holding the last read value.
                    if (MemRead) begin
                        rdata <= mem_data_out;
                    end
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    lh       <= 1'b0;
                    lhu      <= 1'b0;
                    gnt      <= 2'b00;
                    ack      <= win_q ? 2'b10 : 2'b01;
                    state    <= RESP;
                end
                RESP: begin
                    ack   <= 2'b00;
`ifdef DMEM_ARB_CHECK_EN
                    err   <= 2'b00;
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
